// File: rtl/rf_wb_initiator_pkg.sv
// Shared ISA-level register definitions and the register-file request/response types
// used by the write-back initiator and its queue.
package rv32i;
  localparam int reg_width      = 32;
  localparam int reg_addr_width = 5;
  typedef logic [reg_addr_width-1:0] reg_addr_t;
  typedef logic [reg_width-1:0]      reg_t;
  localparam reg_addr_t reg_zero = '0;
endpackage

package core;
  typedef struct packed {
    logic             en;
    rv32i::reg_addr_t addr;
    rv32i::reg_t      value;
  } rf_write_req_t;

  localparam rf_write_req_t rf_write_req_rst = '0;

  typedef struct packed {
    logic done;
  } rf_write_rsp_t;

  typedef struct packed {
    logic             en;
    rv32i::reg_addr_t addr;
  } rf_read_req_t;

  typedef struct packed {
    logic        valid;
    rv32i::reg_t value;
  } rf_read_rsp_t;

  typedef struct packed {
    rv32i::reg_addr_t reg_addr;
    rv32i::reg_t      value;
  } rf_wbq_entry_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} rf_wbq_state_t;

  // x0 reads never conflict with a queued write
  function automatic logic rf_raw_hit(rf_read_req_t req, rf_wbq_entry_t e);
    return req.en && (req.addr != rv32i::reg_zero) && (req.addr == e.reg_addr);
  endfunction
endpackage

// File: rtl/rf_wbq_fifo.sv
// Write-back queue: circular buffer whose contents are also exposed oldest-first
// (entries[0] is the head) with a valid vector, so the top can compare every queued write.
module rf_wbq_fifo
  import core::*;
#(
  parameter int depth = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  rf_wbq_entry_t             push_entry,
  input  logic                      pop,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(depth):0]    count,
  output rf_wbq_entry_t             entries [depth],
  output logic [depth-1:0]          entry_valid
);
  localparam int iw = $clog2(depth);

  logic [iw:0]   wr_ptr, rd_ptr;
  rf_wbq_entry_t mem [depth];
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[iw-1:0]] <= push_entry;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[iw] != rd_ptr[iw]) && (wr_ptr[iw-1:0] == rd_ptr[iw-1:0]);
  assign count = wr_ptr - rd_ptr;

  for (genvar k = 0; k < depth; k++) begin : g_age
    logic [iw-1:0] idx;
    assign idx            = rd_ptr[iw-1:0] + iw'(k);
    assign entries[k]     = mem[idx];
    assign entry_valid[k] = ((iw+1)'(k) < count);
  end
endmodule

// File: rtl/rf_wb_initiator.sv
// Queues retiring results and issues them to the register file one at a time, popping on done;
// decode reads pass through and stall on RAW against the queue, or forward when RF_WBQ_FWD_EN is defined.
module rf_wb_initiator
  import core::*;
#(
  parameter int read_port_cnt = 3,
  parameter int wbq_depth     = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wb_valid,
  output logic                             wb_ready,
  input  logic [rv32i::reg_addr_width-1:0] wb_addr,
  input  logic [rv32i::reg_width-1:0]      wb_value,
  input  rf_read_req_t                     rd_req_in   [read_port_cnt],
  output rf_read_rsp_t                     rd_rsp_out  [read_port_cnt],
  output logic                             rd_stall,
  output rf_write_req_t                    rf_write_req,
  input  rf_write_rsp_t                    rf_write_rsp,
  output rf_read_req_t                     rf_read_req [read_port_cnt],
  input  rf_read_rsp_t                     rf_read_rsp [read_port_cnt],
  output logic                             idle
);
  localparam int cw = $clog2(wbq_depth) + 1;

  rf_wbq_state_t         state, state_nxt;
  logic                  push, pop, full, empty;
  logic [cw-1:0]         wbq_count;
  rf_wbq_entry_t         push_entry;
  rf_wbq_entry_t         entries [wbq_depth];
  logic [wbq_depth-1:0]  entry_valid;
  rf_write_req_t         head_req;

  assign wb_ready   = !full && rst_n;
  assign push       = wb_valid && wb_ready && (wb_addr != rv32i::reg_zero);
  assign push_entry = '{reg_addr: wb_addr, value: wb_value};

  rf_wbq_fifo #(.depth(wbq_depth)) u_wbq (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .count       (wbq_count),
    .entries     (entries),
    .entry_valid (entry_valid)
  );

  assign head_req = '{en: 1'b1, addr: entries[0].reg_addr, value: entries[0].value};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // done is only honoured in WAIT so a response left over from the previous write cannot pop
  always_comb begin
    state_nxt    = state;
    rf_write_req = rf_write_req_rst;
    pop          = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = ISSUE;
      end
      ISSUE: begin
        rf_write_req = head_req;
        state_nxt    = WAIT;
      end
      WAIT: begin
        rf_write_req = head_req;
        if (rf_write_rsp.done) begin
          pop       = 1'b1;
          state_nxt = ((wbq_count > cw'(1)) || push) ? ISSUE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign idle        = empty && (state == IDLE);
  assign rf_read_req = rd_req_in;

  always_comb begin
    rd_stall = 1'b0;
    for (int i = 0; i < read_port_cnt; i++) begin
      rd_rsp_out[i] = rf_read_rsp[i];
`ifdef RF_WBQ_FWD_EN
      // ascending age order, so the youngest matching entry wins
      for (int k = 0; k < wbq_depth; k++) begin
        if (entry_valid[k] && rf_raw_hit(rd_req_in[i], entries[k])) begin
          rd_rsp_out[i].valid = 1'b1;
          rd_rsp_out[i].value = entries[k].value;
        end
      end
`else
      for (int k = 0; k < wbq_depth; k++) begin
        if (entry_valid[k] && rf_raw_hit(rd_req_in[i], entries[k])) rd_stall = 1'b1;
      end
`endif
    end
`ifndef RF_WBQ_FWD_EN
    for (int i = 0; i < read_port_cnt; i++) begin
      if (rd_stall) rd_rsp_out[i].valid = 1'b0;
    end
`endif
  end
endmodule

// File: tb/tb_rf_wb_initiator.sv
// Directed bench for rf_wb_initiator with a register-file stub that answers done one cycle after
// seeing a write request; expectations are hand-derived cycle by cycle.
module tb_rf_wb_initiator;
  import core::*;

  localparam int ports = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_valid = 1'b0;
  logic          wb_ready, rd_stall, idle;
  logic [4:0]    wb_addr = '0;
  logic [31:0]   wb_value = '0;
  rf_read_req_t  rd_req  [ports];
  rf_read_rsp_t  rd_rsp  [ports];
  rf_read_req_t  rf_rreq [ports];
  rf_read_rsp_t  rf_rrsp [ports];
  rf_write_req_t wreq;
  rf_write_rsp_t wrsp;
  logic          auto_done = 1'b0;
  logic          done_q = 1'b0;
  int            n_chk = 0;
  int            n_pass = 0;
  logic [4:0]    exp_addr [5:13];

  always #5 clk = ~clk;

  always @(posedge clk) done_q <= auto_done && wreq.en;
  assign wrsp = '{done: done_q};

  rf_wb_initiator #(.read_port_cnt(ports), .wbq_depth(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .wb_value     (wb_value),
    .rd_req_in    (rd_req),
    .rd_rsp_out   (rd_rsp),
    .rd_stall     (rd_stall),
    .rf_write_req (wreq),
    .rf_write_rsp (wrsp),
    .rf_read_req  (rf_rreq),
    .rf_read_rsp  (rf_rrsp),
    .idle         (idle)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic req_chk(input string tag, input logic en, input logic [4:0] a, input logic [31:0] v);
    rf_write_req_t e;
    e = '{en: en, addr: a, value: v};
    chk(tag, 64'(wreq), 64'(e));
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < ports; i++) begin
      rd_req[i]  = '{en: 1'b0, addr: 5'd0};
      rf_rrsp[i] = '{valid: 1'b1, value: 32'(i) * 32'h1111};
    end
    exp_addr = '{5'd1, 5'd2, 5'd2, 5'd3, 5'd3, 5'd4, 5'd4, 5'd6, 5'd6};

    // reset
    #1 chk("ready_in_reset", wb_ready, 0);
    cyc(2);
    rst_n = 1'b1;
    #1;
    chk("rst_idle", idle, 1);
    chk("rst_ready", wb_ready, 1);
    chk("rst_stall", rd_stall, 0);
    chk("rst_req", 64'(wreq), 64'(rf_write_req_rst));

    // single write x5 = 0x1234
    cyc; wb_valid = 1'b1; wb_addr = 5'd5; wb_value = 32'h1234; auto_done = 1'b1;
    #1 chk("t1_c0_ready", wb_ready, 1);
    cyc; wb_valid = 1'b0;
    #1 req_chk("t1_c1_req", 0, 0, 0); chk("t1_c1_idle", idle, 0);
    cyc; #1 req_chk("t1_c2_req", 1, 5, 32'h1234);
    cyc; #1 req_chk("t1_c3_req", 1, 5, 32'h1234);
    cyc; #1 chk("t1_c4_idle", idle, 1); req_chk("t1_c4_req", 0, 0, 0);

    // four back-to-back pushes fill the queue, fifth push held
    auto_done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      cyc; wb_valid = 1'b1; wb_addr = 5'(c + 1); wb_value = 32'(c + 1) * 32'h11;
      #1 chk($sformatf("t2_c%0d_ready", c), wb_ready, 1);
    end
    cyc; wb_addr = 5'd6; wb_value = 32'h66; auto_done = 1'b1;
    #1 chk("t2_c4_ready", wb_ready, 0); req_chk("t2_c4_req", 1, 1, 32'h11);
    for (int c = 5; c <= 13; c++) begin
      cyc;
      if (c == 7) wb_valid = 1'b0;
      #1;
      if (c == 5) chk("t2_c5_ready", wb_ready, 0);
      if (c == 6) chk("t2_c6_ready", wb_ready, 1);
      req_chk($sformatf("t2_c%0d_req", c), 1, exp_addr[c], 32'(exp_addr[c]) * 32'h11);
    end
    cyc; #1 chk("t2_c14_idle", idle, 1);

    // RAW hazard on x7
    cyc; wb_valid = 1'b1; wb_addr = 5'd7; wb_value = 32'hAA;
    rd_req[0] = '{en: 1'b1, addr: 5'd7}; rf_rrsp[0] = '{valid: 1'b1, value: 32'h5555};
    #1 chk("t3_c0_stall", rd_stall, 0); chk("t3_c0_pass", 64'(rf_rreq[0]), 64'({1'b1, 5'd7}));
    cyc; wb_valid = 1'b0;
    #1;
`ifdef RF_WBQ_FWD_EN
    chk("t3_c1_stall", rd_stall, 0);
    chk("t3_c1_fwd", 64'(rd_rsp[0]), 64'({1'b1, 32'hAA}));
    chk("t3_c1_p1", 64'(rd_rsp[1]), 64'({1'b1, 32'h1111}));
`else
    chk("t3_c1_stall", rd_stall, 1);
    chk("t3_c1_v0", rd_rsp[0].valid, 0);
    chk("t3_c1_v1", rd_rsp[1].valid, 0);
`endif
    cyc(2);
    #1;
`ifdef RF_WBQ_FWD_EN
    chk("t3_c3_stall", rd_stall, 0);
`else
    chk("t3_c3_stall", rd_stall, 1);
`endif
    cyc; #1 chk("t3_c4_stall", rd_stall, 0); chk("t3_c4_rsp", 64'(rd_rsp[0]), 64'({1'b1, 32'h5555}));
    rd_req[0].en = 1'b0;

    // write to x0 is dropped
    cyc; wb_valid = 1'b1; wb_addr = 5'd0; wb_value = 32'hFFFF;
    #1 chk("t4_ready", wb_ready, 1);
    cyc; wb_valid = 1'b0;
    #1 chk("t4_c1_idle", idle, 1);
    for (int c = 2; c <= 4; c++) begin
      cyc; #1 req_chk($sformatf("t4_c%0d_req", c), 0, 0, 0);
    end

    // done withheld for ten cycles
    auto_done = 1'b0;
    cyc; wb_valid = 1'b1; wb_addr = 5'd9; wb_value = 32'h99;
    cyc; wb_addr = 5'd10; wb_value = 32'hA0;
    cyc; wb_valid = 1'b0;
    #1 req_chk("t5_c2_req", 1, 9, 32'h99);
    for (int c = 3; c <= 12; c++) begin
      cyc; #1 req_chk($sformatf("t5_c%0d_req", c), 1, 9, 32'h99);
    end
    auto_done = 1'b1;
    cyc; #1 req_chk("t5_c13_req", 1, 9, 32'h99);
    cyc; #1 req_chk("t5_c14_req", 1, 10, 32'hA0); chk("t5_c14_idle", idle, 0);
    cyc(2); #1 chk("t5_c16_idle", idle, 1);

    // reset mid-WAIT with three queued entries
    auto_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc; wb_valid = 1'b1; wb_addr = 5'(11 + c); wb_value = 32'(11 + c);
    end
    cyc; wb_valid = 1'b0; rd_req[0] = '{en: 1'b1, addr: 5'd12}; rst_n = 1'b0;
    #1 chk("t6_c3_ready", wb_ready, 0); req_chk("t6_c3_req", 1, 11, 32'd11);
`ifndef RF_WBQ_FWD_EN
    chk("t6_c3_stall", rd_stall, 1);
`endif
    cyc; rst_n = 1'b1; auto_done = 1'b1;
    #1;
    chk("t6_c4_idle", idle, 1);
    chk("t6_c4_req", 64'(wreq), 64'(rf_write_req_rst));
    chk("t6_c4_stall", rd_stall, 0);
    for (int c = 5; c <= 8; c++) begin
      cyc; #1 req_chk($sformatf("t6_c%0d_req", c), 0, 0, 0);
    end
    rd_req[0].en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
